data_memory: RTL and testbench



---
 rtl/data_memory_pkg.sv | 18 +
 rtl/mem_align_unit.sv | 58 +++++
 rtl/data_memory.sv | 153 +++++++++++++++
 tb/tb_data_memory.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/data_memory_pkg.sv
// Shared definitions for the data memory: RV32 load/store funct3 codes and FSM states.
package data_memory_pkg;

  // RV32 load/store access-size codes (funct3)
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Access sequencing states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mem_align_unit.sv
// Combinational byte-lane steering for the data memory.
// Load path: picks the addressed byte/half and sign- or zero-extends it.
// Store path: builds the byte-enable mask and replicates the store data across lanes.
module mem_align_unit
  import data_memory_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  byte_off,
  input  logic [31:0] rd_word,
  input  logic [31:0] wr_data,
  output logic [31:0] load_data,
  output logic [3:0]  byte_en,
  output logic [31:0] wr_word
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  // Load path: lane select followed by extension; half accesses ignore byte_off[0]
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    load_data = rd_word;
    lane_byte = rd_word[{byte_off, 3'b000} +: 8];
    lane_half = byte_off[1] ? rd_word[31:16] : rd_word[15:0];
    case (funct3)
      F3_B:    load_data = {{24{lane_byte[7]}}, lane_byte};
      F3_H:    load_data = {{16{lane_half[15]}}, lane_half};
      F3_BU:   load_data = {24'h000000, lane_byte};
      F3_HU:   load_data = {16'h0000, lane_half};
      default: load_data = rd_word;
    endcase
  end

  // Store path: little-endian byte enables; unknown store codes write nothing
  always_comb begin
    byte_en = 4'b0000;
    wr_word = wr_data;
    case (funct3)
      F3_B: begin
        byte_en = 4'b0001 << byte_off;
        wr_word = {4{wr_data[7:0]}};
      end
      F3_H: begin
        byte_en = byte_off[1] ? 4'b1100 : 4'b0011;
        wr_word = {2{wr_data[15:0]}};
      end
      F3_W: begin
        byte_en = 4'b1111;
        wr_word = wr_data;
      end
      default: begin
        byte_en = 4'b0000;
        wr_word = wr_data;
      end
    endcase
  end

endmodule

// File: rtl/data_memory.sv
// Data-side memory for the RV32IM pipeline. Each load/store holds MEM_BUSYWAIT
// high for LATENCY cycles (starting in the accept cycle), then spends one low
// cycle in DONE while the pipeline advances. The request is latched on accept.
module data_memory
  import data_memory_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        MEM_READ_EN,
  input  logic        MEM_WRITE_EN,
  input  logic [2:0]  FUNCT3,
  input  logic [31:0] ADDRESS,
  input  logic [31:0] WRITE_DATA,
  output logic [31:0] READ_DATA,
  output logic        MEM_BUSYWAIT
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  typedef struct packed {
    logic                  is_store;
    logic                  is_load;
    logic [2:0]            funct3;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [1:0]            byte_off;
    logic [31:0]           wdata;
  } req_t;

  state_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  req_t            req_q, req_d;
  logic [31:0]     read_data_q, read_data_d;

  req_t        live_req;
  req_t        cur_req;
  logic        busy;
  logic        exec;
  logic        mem_we;
  logic [31:0] mem_word;
  logic [31:0] load_data;
  logic [3:0]  byte_en;
  logic [31:0] wr_word;
  logic [31:0] mem [DEPTH];

  // Address bits above the array depth are ignored, so accesses wrap
  logic unused_addr_hi;
  assign unused_addr_hi = ^ADDRESS[31:ADDR_WIDTH+2];

  // Live request as presented by the MEM stage; a simultaneous read+write is a store
  always_comb begin
    live_req          = '0;
    live_req.is_store = MEM_WRITE_EN;
    live_req.is_load  = MEM_READ_EN & ~MEM_WRITE_EN;
    live_req.funct3   = FUNCT3;
    live_req.word_idx = ADDRESS[ADDR_WIDTH+1:2];
    live_req.byte_off = ADDRESS[1:0];
    live_req.wdata    = WRITE_DATA;
  end

  // In IDLE the access can only execute at the accept edge (LATENCY = 1), before the latch is loaded
  assign cur_req  = (state_q == IDLE) ? live_req : req_q;
  assign mem_word = mem[cur_req.word_idx];

  mem_align_unit u_align (
    .funct3    (cur_req.funct3),
    .byte_off  (cur_req.byte_off),
    .rd_word   (mem_word),
    .wr_data   (cur_req.wdata),
    .load_data (load_data),
    .byte_en   (byte_en),
    .wr_word   (wr_word)
  );

  // Next-state, counter, request latch and busywait decode
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_d       = req_q;
    read_data_d = read_data_q;
    busy        = 1'b0;
    exec        = 1'b0;
    case (state_q)
      IDLE: begin
        if (MEM_READ_EN | MEM_WRITE_EN) begin
          busy  = 1'b1;
          req_d = live_req;
          cnt_d = CNT_LOAD;
          if (LATENCY == 1) begin
            exec    = 1'b1;
            state_d = DONE;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        busy  = 1'b1;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_d == '0) begin
          exec    = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (exec && cur_req.is_load) begin
      read_data_d = load_data;
    end
  end

  assign MEM_BUSYWAIT = busy & ~RESET;
  assign READ_DATA    = read_data_q;
  assign mem_we       = exec & cur_req.is_store & ~RESET;

  // Control state registers; reset abandons any access in flight
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_q       <= '0;
      read_data_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      read_data_q <= read_data_d;
    end
  end

  // Byte-masked array write at the executing edge
  always_ff @(posedge CLK) begin
    // NOTE: the array is deliberately not reset; its contents are undefined until stored to.
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) begin
          mem[cur_req.word_idx][b*8 +: 8] <= wr_word[b*8 +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: byte-array reference model, per-cycle
// comparison of busywait/read data, plus literal expectations for key accesses.
module tb_data_memory;

  localparam int ADDR_WIDTH  = 10;
  localparam int LATENCY     = 4;
  localparam int DEPTH_BYTES = 4 << ADDR_WIDTH;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read_en;
  logic        mem_write_en;
  logic [2:0]  funct3;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        busywait;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [7:0]  ref_mem [DEPTH_BYTES];
  logic [31:0] exp_rd   = 32'h0;
  logic        exp_busy = 1'b0;
  bit          chk_en   = 1'b0;
  bit          rec_en   = 1'b0;
  logic        busy_trace[$];

  data_memory #(.ADDR_WIDTH(ADDR_WIDTH), .LATENCY(LATENCY)) dut (
    .CLK          (clk),
    .RESET        (rst),
    .MEM_READ_EN  (mem_read_en),
    .MEM_WRITE_EN (mem_write_en),
    .FUNCT3       (funct3),
    .ADDRESS      (address),
    .WRITE_DATA   (write_data),
    .READ_DATA    (read_data),
    .MEM_BUSYWAIT (busywait)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: loads gather little-endian bytes from the aligned address and extend
  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr);
    int unsigned a;
    int unsigned sz;
    logic [31:0] val;
    case (f3)
      3'b000, 3'b100: sz = 1;
      3'b001, 3'b101: sz = 2;
      default:        sz = 4;
    endcase
    a   = addr % DEPTH_BYTES;
    a   = a - (a % sz);
    val = 32'h0;
    for (int i = 0; i < int'(sz); i++) val = val | (32'(ref_mem[a + i]) << (8 * i));
    if (f3 == 3'b000 && val[7])  val = val | 32'hFFFF_FF00;
    if (f3 == 3'b001 && val[15]) val = val | 32'hFFFF_0000;
    return val;
  endfunction

  // Model: stores write 1/2/4 low bytes of the data at the aligned address
  task automatic model_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
    int unsigned a;
    int unsigned sz;
    case (f3)
      3'b000:  sz = 1;
      3'b001:  sz = 2;
      3'b010:  sz = 4;
      default: sz = 0;
    endcase
    if (sz != 0) begin
      a = addr % DEPTH_BYTES;
      a = a - (a % sz);
      for (int i = 0; i < int'(sz); i++) ref_mem[a + i] = wd[8*i +: 8];
    end
  endtask

  // Compare process: outputs checked against the model every cycle
  always @(negedge clk) begin
    if (chk_en) begin
      check("busywait", {31'h0, busywait}, {31'h0, exp_busy});
      check("read_data", read_data, exp_rd);
      if (rec_en) busy_trace.push_back(busywait);
    end
  end

  // One complete access: busywait expected high for LATENCY cycles, then one low cycle
  task automatic access(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input bit hold, input bit scramble);
    mem_read_en  = rd;
    mem_write_en = wr;
    funct3       = f3;
    address      = addr;
    write_data   = wd;
    exp_busy     = 1'b1;
    for (int c = 0; c < LATENCY; c++) begin
      @(posedge clk); #1;
      if (!hold) begin
        mem_read_en  = 1'b0;
        mem_write_en = 1'b0;
      end
      if (scramble) begin
        address    = 32'h0000_0020;
        funct3     = 3'b000;
        write_data = 32'h0BAD_F00D;
      end
    end
    if (wr)      model_store(f3, addr, wd);
    else if (rd) exp_rd = model_load(f3, addr);
    exp_busy = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic idle_cycle();
    mem_read_en  = 1'b0;
    mem_write_en = 1'b0;
    exp_busy     = 1'b0;
    @(posedge clk); #1;
  endtask

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [9:0] trace_bits;
    rst          = 1'b1;
    mem_read_en  = 1'b0;
    mem_write_en = 1'b0;
    funct3       = 3'b000;
    address      = 32'h0;
    write_data   = 32'h0;
    for (int i = 0; i < DEPTH_BYTES; i++) ref_mem[i] = 8'h00;

    #3;
    check("reset_busywait", {31'h0, busywait}, 32'h0);
    check("reset_read_data", read_data, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;
    @(posedge clk); #1;

    // Word store then load
    access(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 1'b0, 1'b0);
    access(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 1'b0);
    check("lw_0x10", read_data, 32'hDEAD_BEEF);

    // Byte store into lane 3, then byte/half loads
    access(1'b0, 1'b1, 3'b000, 32'h13, 32'hFFFF_FF80, 1'b0, 1'b0);
    access(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 1'b0);
    check("lw_after_sb", read_data, 32'h80AD_BEEF);
    access(1'b1, 1'b0, 3'b000, 32'h13, 32'h0, 1'b0, 1'b0);
    check("lb_0x13", read_data, 32'hFFFF_FF80);
    access(1'b1, 1'b0, 3'b100, 32'h13, 32'h0, 1'b0, 1'b0);
    check("lbu_0x13", read_data, 32'h0000_0080);
    access(1'b1, 1'b0, 3'b001, 32'h12, 32'h0, 1'b0, 1'b0);
    check("lh_0x12", read_data, 32'hFFFF_80AD);
    access(1'b1, 1'b0, 3'b101, 32'h12, 32'h0, 1'b0, 1'b0);
    check("lhu_0x12", read_data, 32'h0000_80AD);
    access(1'b1, 1'b0, 3'b001, 32'h13, 32'h0, 1'b0, 1'b0);
    check("lh_0x13_misaligned", read_data, 32'hFFFF_80AD);
    access(1'b1, 1'b0, 3'b010, 32'h13, 32'h0, 1'b0, 1'b0);
    check("lw_0x13_misaligned", read_data, 32'h80AD_BEEF);

    // Back-to-back loads with MEM_READ_EN held high
    access(1'b0, 1'b1, 3'b010, 32'h14, 32'h1234_5678, 1'b0, 1'b0);
    rec_en = 1'b1;
    access(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 1'b1, 1'b0);
    access(1'b1, 1'b0, 3'b010, 32'h14, 32'h0, 1'b1, 1'b0);
    rec_en = 1'b0;
    idle_cycle();
    trace_bits = '0;
    foreach (busy_trace[i]) trace_bits = {trace_bits[8:0], busy_trace[i]};
    check("b2b_trace_len", busy_trace.size(), 32'd10);
    check("b2b_busy_pattern", {22'h0, trace_bits}, {22'h0, 10'b11_1101_1110});
    check("b2b_second_load", read_data, 32'h1234_5678);

    // Request latched: address changes during BUSY are ignored
    access(1'b0, 1'b1, 3'b010, 32'h20, 32'hA5A5_A5A5, 1'b0, 1'b0);
    access(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 1'b1);
    check("latched_addr", read_data, 32'h80AD_BEEF);

    // Read+write together is a store; READ_DATA unchanged
    access(1'b1, 1'b1, 3'b010, 32'h18, 32'hCAFE_F00D, 1'b0, 1'b0);
    check("rw_keeps_read_data", read_data, 32'h80AD_BEEF);
    access(1'b1, 1'b0, 3'b010, 32'h18, 32'h0, 1'b0, 1'b0);
    check("lw_0x18", read_data, 32'hCAFE_F00D);

    // Unsupported store code writes nothing; reserved load code returns the word
    access(1'b0, 1'b1, 3'b011, 32'h18, 32'hFFFF_FFFF, 1'b0, 1'b0);
    access(1'b1, 1'b0, 3'b110, 32'h18, 32'h0, 1'b0, 1'b0);
    check("f3_110_full_word", read_data, 32'hCAFE_F00D);

    // Reset in busy cycle 2 of a store: store discarded, outputs drop asynchronously
    mem_write_en = 1'b1;
    funct3       = 3'b010;
    address      = 32'h14;
    write_data   = 32'h1111_1111;
    exp_busy     = 1'b1;
    @(posedge clk); #1;
    mem_write_en = 1'b0;
    @(posedge clk); #1;
    rst      = 1'b1;
    exp_busy = 1'b0;
    exp_rd   = 32'h0;
    #1;
    check("midreset_busywait", {31'h0, busywait}, 32'h0);
    check("midreset_read_data", read_data, 32'h0);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    access(1'b1, 1'b0, 3'b010, 32'h14, 32'h0, 1'b0, 1'b0);
    check("store_discarded", read_data, 32'h1234_5678);

    // Address wraps modulo the depth
    access(1'b1, 1'b0, 3'b010, 32'h14 + DEPTH_BYTES, 32'h0, 1'b0, 1'b0);
    check("wrap_lw", read_data, 32'h1234_5678);

    idle_cycle();
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
